traffic_light_monitor: RTL and testbench

- Passive observer on the R/G/Y outputs of the traffic light controller. It decodes the current phase, measures how long each lamp state lasts, and checks the flash sequence and its timing.
- Flags illegal lamp encodings, bad sequence order and phase overruns. Produces a pedestrian walk indication and cycle/abort event pulses.
- Sits beside the controller in the same clock domain; inputs are synchronous and need no synchronizer.

---
 rtl/traffic_light_monitor.sv | 151 +++++++++++++++
 tb/tb_traffic_light_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic light controller's R/G/Y lamps: decodes the
// phase, times each lamp state, and flags illegal encodings, bad order and overruns.
module traffic_light_monitor #(
   parameter int unsigned T_LONG  = 1024,
   parameter int unsigned T_SHORT = 128,
   parameter int unsigned T_Y     = 512,
   parameter int unsigned TOL     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        R,
   input  logic        G,
   input  logic        Y,
   output logic [2:0]  phase,
   output logic [10:0] run_len,
   output logic        walk,
   output logic        cycle_done,
   output logic        abort,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam int unsigned RUN_W = 11;

   localparam logic [2:0] PH_MAIN   = 3'd0;
   localparam logic [2:0] PH_OFF1   = 3'd1;
   localparam logic [2:0] PH_GREEN1 = 3'd2;
   localparam logic [2:0] PH_OFF2   = 3'd3;
   localparam logic [2:0] PH_GREEN2 = 3'd4;
   localparam logic [2:0] PH_YELLOW = 3'd5;
   localparam logic [2:0] PH_RED    = 3'd6;
   localparam logic [2:0] PH_LOST   = 3'd7;

   localparam logic [2:0] ENC_OFF = 3'b000;
   localparam logic [2:0] ENC_G   = 3'b010;
   localparam logic [2:0] ENC_Y   = 3'b001;
   localparam logic [2:0] ENC_R   = 3'b100;

   localparam logic [1:0] EC_ILLEGAL = 2'd1;
   localparam logic [1:0] EC_SEQ     = 2'd2;
   localparam logic [1:0] EC_OVERRUN = 2'd3;

   localparam logic [RUN_W-1:0] RUN_MAX = '1;

   function automatic logic [RUN_W-1:0] exp_len(input logic [2:0] ph);
      case (ph)
         PH_MAIN, PH_RED: exp_len = RUN_W'(T_LONG);
         PH_YELLOW:       exp_len = RUN_W'(T_Y);
         default:         exp_len = RUN_W'(T_SHORT);
      endcase
   endfunction

   function automatic logic [2:0] exp_enc(input logic [2:0] ph);
      case (ph)
         PH_MAIN, PH_GREEN1, PH_GREEN2: exp_enc = ENC_G;
         PH_YELLOW:                     exp_enc = ENC_Y;
         PH_RED:                        exp_enc = ENC_R;
         default:                       exp_enc = ENC_OFF;
      endcase
   endfunction

   logic [2:0]       r_prev;
   logic             r_first;

   logic [2:0]       w_enc;
   logic             w_changed;
   logic             w_illegal;
   logic [RUN_W-1:0] w_run_nxt;
   logic [RUN_W-1:0] w_lo;
   logic [RUN_W-1:0] w_hi;
   logic             w_len_ok;
   logic [2:0]       w_adv;
   logic [2:0]       w_phase_nxt;
   logic             w_cd_nxt;
   logic             w_ab_nxt;
   logic             w_raise;
   logic [1:0]       w_raise_code;
   logic             w_err_nxt;
   logic [1:0]       w_code_nxt;

   // Next-state decode: illegal > lost resync > transition > overrun
   always_comb begin
      w_enc        = {R, G, Y};
      w_changed    = (w_enc != r_prev);
      w_illegal    = (R & G) | (R & Y) | (G & Y);
      w_run_nxt    = w_changed ? RUN_W'(1)
                   : ((run_len == RUN_MAX) ? run_len : RUN_W'(run_len + RUN_W'(1)));
      w_lo         = RUN_W'(exp_len(phase) - RUN_W'(TOL));
      w_hi         = RUN_W'(exp_len(phase) + RUN_W'(TOL));
      // The very first main-green run after reset has an unknown start time
      w_len_ok     = ((r_first && (phase == PH_MAIN)) || (run_len >= w_lo)) && (run_len <= w_hi);
      w_adv        = (phase == PH_RED) ? PH_MAIN : 3'(phase + 3'd1);
      w_phase_nxt  = phase;
      w_cd_nxt     = 1'b0;
      w_ab_nxt     = 1'b0;
      w_raise      = 1'b0;
      w_raise_code = 2'd0;

      if (w_illegal) begin
         w_phase_nxt  = PH_LOST;
         w_raise      = 1'b1;
         w_raise_code = EC_ILLEGAL;
      end else if (phase == PH_LOST) begin
         if (w_changed && (w_enc == ENC_G)) w_phase_nxt = PH_MAIN;
      end else if (w_changed) begin
         if ((w_enc == exp_enc(w_adv)) && w_len_ok) begin
            w_phase_nxt = w_adv;
            w_cd_nxt    = (phase == PH_RED);
         end else if (w_enc == ENC_G) begin
            w_phase_nxt = PH_MAIN;
            w_ab_nxt    = 1'b1;
         end else begin
            w_phase_nxt  = PH_LOST;
            w_raise      = 1'b1;
            w_raise_code = EC_SEQ;
         end
      end else if (w_run_nxt > w_hi) begin
         w_phase_nxt  = PH_LOST;
         w_raise      = 1'b1;
         w_raise_code = EC_OVERRUN;
      end

      w_err_nxt  = err | w_raise;
      w_code_nxt = (w_raise && !err) ? w_raise_code : err_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase      <= PH_MAIN;
         run_len    <= '0;
         walk       <= 1'b0;
         cycle_done <= 1'b0;
         abort      <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'd0;
         r_prev     <= ENC_G;
         r_first    <= 1'b1;
      end else begin
         phase      <= w_phase_nxt;
         run_len    <= w_run_nxt;
         walk       <= (w_phase_nxt == PH_RED);
         cycle_done <= w_cd_nxt;
         abort      <= w_ab_nxt;
         err        <= w_err_nxt;
         err_code   <= w_code_nxt;
         r_prev     <= w_enc;
         if (w_changed) r_first <= 1'b0;
      end
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: clean cycle, abort, errors, tolerance, reset.
module tb_traffic_light_monitor;

   localparam logic [2:0] E_OFF = 3'b000;
   localparam logic [2:0] E_G   = 3'b010;
   localparam logic [2:0] E_Y   = 3'b001;
   localparam logic [2:0] E_R   = 3'b100;

   logic        clk = 1'b0;
   logic        rst;
   logic        r, g, y;
   logic [2:0]  phase;
   logic [10:0] run_len;
   logic        walk, cycle_done, abort, err;
   logic [1:0]  err_code;

   int n_checks = 0;
   int n_pass   = 0;
   int n_walk   = 0;
   int n_cd     = 0;
   int n_ab     = 0;

   traffic_light_monitor dut (
      .clk(clk), .rst(rst), .R(r), .G(g), .Y(y),
      .phase(phase), .run_len(run_len), .walk(walk),
      .cycle_done(cycle_done), .abort(abort), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic step(input logic [2:0] enc);
      {r, g, y} = enc;
      @(posedge clk);
      #1;
      if (walk) n_walk++;
      if (cycle_done) n_cd++;
      if (abort) n_ab++;
   endtask

   task automatic run(input logic [2:0] enc, input int n);
      for (int i = 0; i < n; i++) step(enc);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      {r, g, y} = E_G;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic flash();
      run(E_OFF, 128); run(E_G, 128); run(E_OFF, 128); run(E_G, 128);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      {r, g, y} = E_G;
      #12;
      n_checks++; if ({phase, run_len, walk, cycle_done, abort, err, err_code} !== 18'd0)
         $display("FAIL reset_vals got ph=%0d len=%0d w=%0d cd=%0d ab=%0d err=%0d code=%0d want all 0",
                  phase, run_len, walk, cycle_done, abort, err, err_code); else n_pass++;
      @(posedge clk); #1; rst = 1'b0;
      step(E_G);
      n_checks++; if (run_len !== 11'd1) $display("FAIL reset_first_len got %0d want 1", run_len); else n_pass++;
   endtask

   task automatic test_clean_cycle();
      logic [2:0] encs [7];
      int         lens [7];
      encs = '{E_G, E_OFF, E_G, E_OFF, E_G, E_Y, E_R};
      lens = '{1024, 128, 128, 128, 128, 512, 1024};
      do_reset();
      n_cd = 0;
      for (int i = 0; i < 7; i++) begin
         if (i == 6) n_walk = 0;
         step(encs[i]);
         n_checks++; if (phase !== 3'(i)) $display("FAIL clean_phase%0d got %0d want %0d", i, phase, i); else n_pass++;
         run(encs[i], lens[i] - 1);
      end
      step(E_G);
      n_checks++; if (phase !== 3'd0 || cycle_done !== 1'b1)
         $display("FAIL clean_wrap got ph=%0d cd=%0d want ph=0 cd=1", phase, cycle_done); else n_pass++;
      n_checks++; if (n_walk !== 1024) $display("FAIL clean_walk_len got %0d want 1024", n_walk); else n_pass++;
      n_checks++; if (n_cd !== 1 || err !== 1'b0)
         $display("FAIL clean_cd_err got cd=%0d err=%0d want cd=1 err=0", n_cd, err); else n_pass++;
   endtask

   task automatic test_abort();
      run(E_G, 1023); flash(); run(E_Y, 200);
      n_ab = 0;
      n_checks++; if (phase !== 3'd5) $display("FAIL abort_pre got ph=%0d want 5", phase); else n_pass++;
      step(E_G);
      n_checks++; if (abort !== 1'b1 || phase !== 3'd0 || err !== 1'b0)
         $display("FAIL abort_pulse got ab=%0d ph=%0d err=%0d want 1/0/0", abort, phase, err); else n_pass++;
      run(E_G, 1023); flash(); run(E_Y, 512); run(E_R, 1024);
      n_cd = 0;
      step(E_G);
      n_checks++; if (cycle_done !== 1'b1 || phase !== 3'd0 || err !== 1'b0 || n_ab !== 1)
         $display("FAIL abort_next got cd=%0d ph=%0d err=%0d nab=%0d want 1/0/0/1",
                  cycle_done, phase, err, n_ab); else n_pass++;
   endtask

   task automatic test_overrun();
      do_reset();
      run(E_G, 1024); flash(); run(E_Y, 513);
      n_checks++; if (phase !== 3'd5 || err !== 1'b0 || run_len !== 11'd513)
         $display("FAIL ovr_edge got ph=%0d err=%0d len=%0d want 5/0/513", phase, err, run_len); else n_pass++;
      step(E_Y);
      n_checks++; if (phase !== 3'd7 || err !== 1'b1 || err_code !== 2'd3 || run_len !== 11'd514)
         $display("FAIL ovr_trip got ph=%0d err=%0d code=%0d len=%0d want 7/1/3/514",
                  phase, err, err_code, run_len); else n_pass++;
      run(E_Y, 6);
      n_checks++; if (run_len !== 11'd520 || phase !== 3'd7)
         $display("FAIL ovr_count got len=%0d ph=%0d want 520/7", run_len, phase); else n_pass++;
   endtask

   task automatic test_sequence();
      do_reset();
      run(E_G, 1024); flash(); run(E_Y, 512); run(E_R, 1024);
      n_checks++; if (phase !== 3'd6 || walk !== 1'b1)
         $display("FAIL seq_red got ph=%0d walk=%0d want 6/1", phase, walk); else n_pass++;
      step(E_Y);
      n_checks++; if (phase !== 3'd7 || err_code !== 2'd2 || walk !== 1'b0)
         $display("FAIL seq_err got ph=%0d code=%0d walk=%0d want 7/2/0", phase, err_code, walk); else n_pass++;
      run(E_Y, 600);
      n_checks++; if (err_code !== 2'd2 || run_len !== 11'd601)
         $display("FAIL seq_sticky got code=%0d len=%0d want 2/601", err_code, run_len); else n_pass++;
   endtask

   task automatic test_illegal_recovery();
      do_reset();
      run(E_G, 1024); run(E_OFF, 128); run(E_G, 10);
      n_checks++; if (phase !== 3'd2) $display("FAIL ill_pre got ph=%0d want 2", phase); else n_pass++;
      step(3'b110);
      n_checks++; if (phase !== 3'd7 || err !== 1'b1 || err_code !== 2'd1)
         $display("FAIL ill_trip got ph=%0d err=%0d code=%0d want 7/1/1", phase, err, err_code); else n_pass++;
      run(E_OFF, 5);
      n_checks++; if (phase !== 3'd7) $display("FAIL lost_hold got ph=%0d want 7", phase); else n_pass++;
      step(E_G);
      n_checks++; if (phase !== 3'd0 || err !== 1'b1 || err_code !== 2'd1 || abort !== 1'b0)
         $display("FAIL lost_resync got ph=%0d err=%0d code=%0d ab=%0d want 0/1/1/0",
                  phase, err, err_code, abort); else n_pass++;
      run(E_G, 50);
      rst = 1'b1;
      #1;
      n_checks++; if ({phase, run_len, walk, cycle_done, abort, err, err_code} !== 18'd0)
         $display("FAIL async_rst got ph=%0d len=%0d err=%0d code=%0d want all 0",
                  phase, run_len, err, err_code); else n_pass++;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_tolerance();
      do_reset();
      run(E_G, 5);
      step(E_OFF);
      n_checks++; if (phase !== 3'd1 || err !== 1'b0)
         $display("FAIL tol_first_exempt got ph=%0d err=%0d want 1/0", phase, err); else n_pass++;
      run(E_OFF, 128);
      step(E_G);
      n_checks++; if (phase !== 3'd2) $display("FAIL tol_upper got ph=%0d want 2", phase); else n_pass++;
      run(E_G, 126);
      step(E_OFF);
      n_checks++; if (phase !== 3'd3) $display("FAIL tol_lower got ph=%0d want 3", phase); else n_pass++;
      run(E_OFF, 125);
      n_ab = 0;
      step(E_G);
      n_checks++; if (phase !== 3'd0 || abort !== 1'b1 || err !== 1'b0)
         $display("FAIL tol_short got ph=%0d ab=%0d err=%0d want 0/1/0", phase, abort, err); else n_pass++;
      do_reset();
      run(E_G, 1025);
      n_checks++; if (phase !== 3'd0 || err !== 1'b0)
         $display("FAIL first_hi got ph=%0d err=%0d want 0/0", phase, err); else n_pass++;
      step(E_G);
      n_checks++; if (phase !== 3'd7 || err_code !== 2'd3)
         $display("FAIL first_ovr got ph=%0d code=%0d want 7/3", phase, err_code); else n_pass++;
      run(E_G, 1100);
      n_checks++; if (run_len !== 11'd2047) $display("FAIL run_sat got %0d want 2047", run_len); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_clean_cycle();
      test_abort();
      test_overrun();
      test_sequence();
      test_illegal_recovery();
      test_tolerance();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
